irq_arbiter_wb: RTL

//  Platform interrupt controller for the barebones Wishbone SoC. Collects N_SRC

---
 rtl/irq_arbiter_wb_if.sv | 23 ++
 rtl/irq_arbiter_wb.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/irq_arbiter_wb_if.sv
// Wishbone slave bundle for the platform interrupt controller register port.
interface irq_arbiter_wb_if;
   localparam int unsigned ADR_W = 8;
   localparam int unsigned DAT_W = 32;

   logic             wb_cyc_i;
   logic             wb_stb_i;
   logic             wb_we_i;
   logic [ADR_W-1:0] wb_adr_i;
   logic [DAT_W-1:0] wb_dat_i;
   logic             wb_ack_o;
   logic [DAT_W-1:0] wb_dat_o;

   modport slave (
      input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
      output wb_ack_o, wb_dat_o
   );

   modport master (
      output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
      input  wb_ack_o, wb_dat_o
   );
endinterface

// File: rtl/irq_arbiter_wb.sv
// Platform interrupt controller: per-source gateways, priority arbiter and
// claim/complete register file behind a Wishbone slave port; drives meip_o.
module irq_arbiter_wb #(
   parameter int unsigned      N_SRC     = 8,
   parameter int unsigned      PRIO_W    = 3,
   parameter logic [N_SRC-1:0] EDGE_MASK = '0
) (
   input  logic             clk_i,
   input  logic             reset_i,
   irq_arbiter_wb_if.slave  wb,
   input  logic [N_SRC-1:0] irq_src_i,
   input  logic             irq_ack_i,
   output logic             meip_o
);

   localparam int unsigned ID_W    = 5;
   localparam int unsigned WORD_W  = 6;
   localparam int unsigned DAT_W   = 32;
   localparam int unsigned A_PRIO0 = 8;

   localparam logic [WORD_W-1:0] A_PENDING = 6'd0;
   localparam logic [WORD_W-1:0] A_ENABLE  = 6'd1;
   localparam logic [WORD_W-1:0] A_THRESH  = 6'd2;
   localparam logic [WORD_W-1:0] A_CLAIM   = 6'd3;
   localparam logic [WORD_W-1:0] A_ACK_ID  = 6'd4;

   logic [N_SRC-1:0]  r_pending;
   logic [N_SRC-1:0]  r_in_service;
   logic [N_SRC-1:0]  r_enable;
   logic [N_SRC-1:0]  r_prev;
   logic [PRIO_W-1:0] r_threshold;
   logic [PRIO_W-1:0] r_prio [N_SRC];
   logic [ID_W-1:0]   r_ack_id;
   logic              r_ack;
   logic              r_meip;
   logic [DAT_W-1:0]  r_dat;

   logic              w_req;
   logic              w_write;
   logic              w_wb_claim;
   logic              w_hw_claim;
   logic              w_claim;
   logic              w_complete;
   logic [WORD_W-1:0] w_word;
   logic [ID_W-1:0]   w_cpl_id;
   logic [ID_W-1:0]   w_best_id;
   logic [N_SRC-1:0]  w_elig;
   logic [N_SRC-1:0]  w_claim_mask;
   logic [N_SRC-1:0]  w_cpl_mask;
   logic [N_SRC-1:0]  w_pending_nxt;
   logic [DAT_W-1:0]  w_rdata;
   logic              w_unused;

   assign wb.wb_ack_o = r_ack;
   assign wb.wb_dat_o = r_dat;
   assign meip_o      = r_meip;

   // A strobe is accepted only while ack is low, so back-to-back strobes ack every other cycle.
   assign w_req      = wb.wb_cyc_i & wb.wb_stb_i & ~r_ack;
   assign w_write    = w_req & wb.wb_we_i;
   assign w_word     = wb.wb_adr_i[7:2];
   assign w_cpl_id   = wb.wb_dat_i[ID_W-1:0];
   assign w_wb_claim = w_req & ~wb.wb_we_i & (w_word == A_CLAIM);
   assign w_hw_claim = irq_ack_i & ~w_wb_claim;
   assign w_claim    = w_wb_claim | w_hw_claim;
   assign w_complete = w_write & (w_word == A_CLAIM);
   assign w_unused   = ^{wb.wb_dat_i, wb.wb_adr_i[1:0]};

   // Arbiter: strict '>' while scanning upward keeps the lowest ID on a priority tie.
   always_comb begin
      logic [PRIO_W-1:0] v_prio;
      v_prio    = r_threshold;
      w_best_id = '0;
      w_elig    = '0;
      for (int unsigned k = 0; k < N_SRC; k++) begin
         w_elig[k] = r_pending[k] & r_enable[k] & (r_prio[k] > r_threshold);
         if (w_elig[k] && (r_prio[k] > v_prio)) begin
            v_prio    = r_prio[k];
            w_best_id = ID_W'(k + 1);
         end
      end
   end

   // Gateways; a claim overrides the gateway for the claimed source.
   always_comb begin
      w_claim_mask  = '0;
      w_cpl_mask    = '0;
      w_pending_nxt = '0;
      for (int unsigned k = 0; k < N_SRC; k++) begin
         w_claim_mask[k] = w_claim & (w_best_id == ID_W'(k + 1));
         w_cpl_mask[k]   = w_complete & (w_cpl_id == ID_W'(k + 1));
         if (EDGE_MASK[k]) begin
            w_pending_nxt[k] = r_pending[k] | (irq_src_i[k] & ~r_prev[k] & ~r_in_service[k]);
         end else begin
            w_pending_nxt[k] = irq_src_i[k] & ~r_in_service[k];
         end
         w_pending_nxt[k] = w_pending_nxt[k] & ~w_claim_mask[k];
      end
   end

   always_comb begin
      w_rdata = '0;
      case (w_word)
         A_PENDING: w_rdata = DAT_W'({r_pending, 1'b0});
         A_ENABLE:  w_rdata = DAT_W'({r_enable, 1'b0});
         A_THRESH:  w_rdata = DAT_W'(r_threshold);
         A_CLAIM:   w_rdata = DAT_W'(w_best_id);
         A_ACK_ID:  w_rdata = DAT_W'(r_ack_id);
         default: begin
            for (int unsigned k = 0; k < N_SRC; k++) begin
               if (w_word == WORD_W'(A_PRIO0 + k)) w_rdata = DAT_W'(r_prio[k]);
            end
         end
      endcase
   end

   // meip_o excludes the source being claimed so it falls the cycle after the claim.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_pending    <= '0;
         r_in_service <= '0;
         r_enable     <= '0;
         r_prev       <= '0;
         r_threshold  <= '0;
         r_ack_id     <= '0;
         r_ack        <= 1'b0;
         r_meip       <= 1'b0;
         r_dat        <= '0;
         for (int unsigned k = 0; k < N_SRC; k++) r_prio[k] <= '0;
      end else begin
         r_ack        <= w_req;
         r_prev       <= irq_src_i;
         r_pending    <= w_pending_nxt;
         r_in_service <= (r_in_service & ~w_cpl_mask) | w_claim_mask;
         r_meip       <= |(w_elig & ~w_claim_mask);
         if (w_hw_claim) r_ack_id <= w_best_id;
         if (w_req) r_dat <= w_rdata;
         if (w_write) begin
            case (w_word)
               A_ENABLE: r_enable    <= wb.wb_dat_i[N_SRC:1];
               A_THRESH: r_threshold <= wb.wb_dat_i[PRIO_W-1:0];
               default: begin
                  for (int unsigned k = 0; k < N_SRC; k++) begin
                     if (w_word == WORD_W'(A_PRIO0 + k)) r_prio[k] <= wb.wb_dat_i[PRIO_W-1:0];
                  end
               end
            endcase
         end
      end
   end

endmodule
